// File: rtl/receiver_conditioner.sv
// Per-channel RC receiver conditioner: validates reader pulse widths, averages the last
// four accepted frames, scales to an 8-bit stick value and falls back to failsafe on loss.
module receiver_conditioner #(
  parameter int WIDTH_BITS      = 10,
  parameter int MAX_COUNT       = 400,
  parameter int REJECT_MARGIN   = 40,
  parameter int MIN_HIGH_CYCLES = 26600,
  parameter int TIMEOUT_CYCLES  = 2660000,
  parameter int ACQ_FRAMES      = 4,
  parameter int FAILSAFE_WIDTH  = 0
) (
  input  logic                  sys_clk,
  input  logic                  resetn,
  input  logic                  pwm_in,
  input  logic [WIDTH_BITS-1:0] raw_width,
  output logic [WIDTH_BITS-1:0] width_out,
  output logic [7:0]            stick_out,
  output logic                  valid,
  output logic                  failsafe,
  output logic                  update
);

  localparam int HCW = $clog2(MIN_HIGH_CYCLES + 1);
  localparam int SW  = WIDTH_BITS + 2;

  localparam logic [1:0] ST_FAILSAFE = 2'd0;
  localparam logic [1:0] ST_ACQUIRE  = 2'd1;
  localparam logic [1:0] ST_TRACK    = 2'd2;

  localparam logic [WIDTH_BITS:0]   LIMIT    = (WIDTH_BITS+1)'(MAX_COUNT + REJECT_MARGIN);
  localparam logic [WIDTH_BITS-1:0] MAXW     = WIDTH_BITS'(MAX_COUNT);
  localparam logic [WIDTH_BITS-1:0] FS_W     = WIDTH_BITS'(FAILSAFE_WIDTH);
  localparam logic [7:0]            FS_STICK = 8'((FAILSAFE_WIDTH * 163) >> 8);
  localparam logic [HCW-1:0]        HC_MAX   = HCW'(MIN_HIGH_CYCLES);
  localparam logic [21:0]           TO_MAX   = 22'(TIMEOUT_CYCLES);
  localparam logic [2:0]            ACQ_LAST = 3'(ACQ_FRAMES - 1);

  typedef struct packed {
    logic [WIDTH_BITS-1:0] width;
    logic [7:0]            stick;
    logic                  valid;
    logic                  failsafe;
  } out_t;

  localparam out_t OUT_FS = '{width: FS_W, stick: FS_STICK, valid: 1'b0, failsafe: 1'b1};

  // sync[1:0] is the synchroniser, sync[2] the previous synced value for edge detect
  logic [2:0]                 sync;
  logic                       fall, fall_d;
  logic [HCW-1:0]             hcnt;
  logic [21:0]                tcnt;
  logic [3:0][WIDTH_BITS-1:0] hist;
  logic                       accept, acc_d, tmo;
  logic [WIDTH_BITS-1:0]      samp, avg;
  logic [SW-1:0]              sum;
  logic [7:0]                 stick;
  logic [1:0]                 state;
  logic [2:0]                 acq;
  out_t                       outs;

  always_comb begin
    fall   = sync[2] & ~sync[1];
    accept = fall & (hcnt == HC_MAX) & ({1'b0, raw_width} <= LIMIT);
    samp   = (raw_width > MAXW) ? MAXW : raw_width;
    tmo    = (tcnt == TO_MAX) & ~accept;
    sum    = SW'(hist[0]) + SW'(hist[1]) + SW'(hist[2]) + SW'(hist[3]);
    avg    = WIDTH_BITS'(sum >> 2);
    stick  = 8'((17'(avg) * 17'd163) >> 8);
  end

  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      sync   <= '0;
      fall_d <= 1'b0;
      acc_d  <= 1'b0;
      hcnt   <= '0;
      tcnt   <= '0;
      hist   <= '0;
    end else begin
      sync   <= {sync[1], sync[0], pwm_in};
      fall_d <= fall;
      acc_d  <= accept;
      if (fall_d)                     hcnt <= '0;
      else if (sync[1] && hcnt != HC_MAX) hcnt <= hcnt + 1'b1;
      if (accept)                     tcnt <= '0;
      else if (tcnt != TO_MAX)        tcnt <= tcnt + 1'b1;
      if (accept)                     hist <= {hist[2:0], samp};
    end
  end

  always_ff @(posedge sys_clk or negedge resetn) begin
    if (!resetn) begin
      state  <= ST_FAILSAFE;
      acq    <= '0;
      outs   <= OUT_FS;
      update <= 1'b0;
    end else begin
      update <= 1'b0;
      case (state)
        ST_FAILSAFE: if (accept) begin
          state <= ST_ACQUIRE;
          acq   <= 3'd1;
        end
        ST_ACQUIRE: begin
          if (accept) begin
            if (acq == ACQ_LAST) begin
              state <= ST_TRACK;
              acq   <= '0;
            end else begin
              acq <= acq + 1'b1;
            end
          end else if (tmo) begin
            state <= ST_FAILSAFE;
            acq   <= '0;
          end else if (fall) begin
            acq <= '0;
          end
        end
        ST_TRACK: if (tmo) begin
          state  <= ST_FAILSAFE;
          outs   <= OUT_FS;
          update <= 1'b1;
        end
        default: state <= ST_FAILSAFE;
      endcase
      // history was shifted on the accept edge, so avg already includes this frame
      if (state == ST_TRACK && acc_d) begin
        outs   <= '{width: avg, stick: stick, valid: 1'b1, failsafe: 1'b0};
        update <= 1'b1;
      end
    end
  end

  assign width_out = outs.width;
  assign stick_out = outs.stick;
  assign valid     = outs.valid;
  assign failsafe  = outs.failsafe;

endmodule
